fetch_pc_ctrl: RTL

- IF-stage PC generator and IF/ID pipeline register; directly upstream of the 2-bit correlating branch-prediction handler.
- Supplies that handler with the IF opcode, the low PC index bits and the IF/ID fields.
- Consumes its br_prediction, flush, jump_detected and branch_hazard_stall to select the next PC.
- Holds the recovery state needed to redirect fetch after a misprediction, and counts resolved branches and mispredictions.

---
 rtl/fetch_pc_ctrl.sv | 79 +++++++
 1 files changed

// File: rtl/fetch_pc_ctrl.sv
// fetch_pc_ctrl: IF-stage next-PC selection, IF/ID pipeline register and saturating branch/mispredict counters
module fetch_pc_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      instr_IF,
  input  logic             br_prediction,
  input  logic             jump_detected,
  input  logic             flush,
  input  logic             branch_hazard_stall,
  input  logic             load_use_stall,
  output logic [31:0]      pc_IF,
  output logic [5:0]       opcode_IF,
  output logic [4:0]       branch_addr_lw_5b,
  output logic [31:0]      IFID_instr,
  output logic [31:0]      IFID_pc_plus4,
  output logic             IFID_valid,
  output logic [5:0]       opcode_ID,
  output logic [CNT_W-1:0] br_count,
  output logic [CNT_W-1:0] mispred_count
);
  logic [31:0] pc_q, pc_d, instr_q, instr_d, ppc4_q, ppc4_d, tgt_q, tgt_d;
  logic [31:0] pc_plus4, br_target_IF, jmp_target;
  logic valid_q, valid_d, pred_q, pred_d, stall, load, bub;
  logic [CNT_W-1:0] br_q, br_d, mis_q, mis_d;
  always_comb begin
    pc_plus4 = pc_q + 32'd4;
    br_target_IF = pc_plus4 + {{14{instr_IF[15]}}, instr_IF[15:0], 2'b00};
    jmp_target = {pc_plus4[31:28], instr_IF[25:0], 2'b00};
    stall = branch_hazard_stall | load_use_stall;
    bub = flush | (!stall & jump_detected);
    load = !flush & !stall & !jump_detected;
    pc_d = flush ? (pred_q ? ppc4_q : tgt_q) :
           stall ? pc_q :
           jump_detected ? jmp_target :
           br_prediction ? br_target_IF : pc_plus4;
    instr_d = load ? instr_IF : bub ? 32'h0 : instr_q;
    ppc4_d = load ? pc_plus4 : ppc4_q;
    tgt_d = load ? br_target_IF : tgt_q;
    valid_d = load ? 1'b1 : bub ? 1'b0 : valid_q;
    pred_d = load ? br_prediction : bub ? 1'b0 : pred_q;
    br_d = (valid_q && instr_q[31:26] == 6'b000100 && !stall && !(&br_q)) ? br_q + CNT_W'(1) : br_q;
    mis_d = (flush && !(&mis_q)) ? mis_q + CNT_W'(1) : mis_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q <= RESET_PC;
      instr_q <= '0;
      ppc4_q <= '0;
      tgt_q <= '0;
      valid_q <= 1'b0;
      pred_q <= 1'b0;
      br_q <= '0;
      mis_q <= '0;
    end else begin
      pc_q <= pc_d;
      instr_q <= instr_d;
      ppc4_q <= ppc4_d;
      tgt_q <= tgt_d;
      valid_q <= valid_d;
      pred_q <= pred_d;
      br_q <= br_d;
      mis_q <= mis_d;
    end
  end
  assign pc_IF = pc_q;
  assign opcode_IF = instr_IF[31:26];
  assign branch_addr_lw_5b = pc_q[6:2];
  assign IFID_instr = instr_q;
  assign IFID_pc_plus4 = ppc4_q;
  assign IFID_valid = valid_q;
  assign opcode_ID = instr_q[31:26];
  assign br_count = br_q;
  assign mispred_count = mis_q;
  a_flush_no_stall: assert property (@(posedge clk) disable iff (rst)
    !(flush && (branch_hazard_stall || load_use_stall)));
endmodule
